// File: rtl/switch_debouncer_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer_if
//  Description : Bundle of the slide-switch conditioning signals.
//                  switch_raw : raw asynchronous switch levels from the pins
//                  switch     : debounced, clock-synchronous switch levels
//                  changed    : one-cycle strobe after any debounced update
//                The slave modport is the debouncer itself; the master
//                modport is the side that owns the pins and consumes the
//                clean levels.
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_debouncer_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] switch_raw;
    logic [WIDTH-1:0] switch;
    logic             changed;

    modport master (
        output switch_raw,
        input  switch,
        input  changed
    );

    modport slave (
        input  switch_raw,
        output switch,
        output changed
    );
endinterface : switch_debouncer_if
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : switch_debouncer
//  Description : Synchronises and debounces WIDTH independent slide-switch
//                lines. Each line passes through a two-flop synchroniser;
//                the synchronised level must differ from the debounced
//                level for STABLE_CYCLES consecutive edges before it is
//                accepted. Any return to the debounced level clears the
//                count, so short glitches and bounce are discarded.
//                A registered strobe pulses for one cycle after any edge
//                at which at least one debounced bit updated.
//
//  Ports       : clk            system clock, rising-edge active
//                rst_n          asynchronous active-low reset
//                bus.switch_raw raw switch levels (asynchronous)
//                bus.switch     debounced levels ([4:2] function select,
//                               [1:0] operands on the board)
//                bus.changed    one-cycle strobe after a debounced update
//
//  Parameters  : WIDTH          number of switch lines, must match the
//                               WIDTH of the connected interface
//                STABLE_CYCLES  acceptance time in cycles, legal >= 2
//                               (1000000 = 10 ms at 100 MHz)
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int WIDTH         = 5,
    parameter int STABLE_CYCLES = 1000000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    switch_debouncer_if.slave  bus
);

    // Counter only has to reach STABLE_CYCLES-1, so $clog2 bits suffice.
    localparam int                 c_CNT_W   = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Only r_s2 is used by the debounce logic; r_s1
    // may go metastable and is given a full cycle to resolve.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= bus.switch_raw;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-bit stability counters. Each bit raises w_update[i] on the edge at
    // which its synchronised level has disagreed with the debounced level
    // for STABLE_CYCLES consecutive evaluations.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_switch;
    logic [WIDTH-1:0] w_update;
    logic             r_changed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_mismatch;
        logic               w_expired;

        assign w_mismatch  = r_s2[i] ^ r_switch[i];
        assign w_expired   = (r_cnt == c_CNT_MAX);
        assign w_update[i] = w_mismatch & w_expired;

        // Cleared whenever the input agrees with the output (bounce restarts
        // the count) and on acceptance, so it never needs to wrap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (!w_mismatch || w_expired) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end : g_bit

    // ------------------------------------------------------------------------
    // Debounced outputs. An accepted bit always flips (it only updates on a
    // mismatch), so XOR with the update mask loads the new level. The strobe
    // covers every bit updating on the same edge with a single pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_switch  <= '0;
            r_changed <= 1'b0;
        end else begin
            r_switch  <= r_switch ^ w_update;
            r_changed <= |w_update;
        end
    end

    assign bus.switch  = r_switch;
    assign bus.changed = r_changed;

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_debouncer
//  Description : Self-checking bench for switch_debouncer with WIDTH=5 and
//                STABLE_CYCLES=4. A window model decides each edge whether
//                the last STABLE_CYCLES synchronised samples of a bit all
//                disagree with its debounced value; outputs are compared to
//                the model every cycle, with literal checks at key points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int WIDTH = 5;
    localparam int S     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    switch_debouncer_if #(.WIDTH(WIDTH)) bus ();

    switch_debouncer #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (S)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Model: the value seen by the debounce logic at edge t is the raw value
    // sampled at edge t-2 (0 before reset history exists). A bit flips when
    // the S most recent seen values all differ from its current output.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] rawq[$];
    logic [WIDTH-1:0] seenq[$];
    logic [WIDTH-1:0] m_sw;
    logic             m_chg;
    logic [WIDTH-1:0] m_seen;
    logic [WIDTH-1:0] m_upd;
    bit               m_all;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rawq.delete();
            seenq.delete();
            m_sw  = '0;
            m_chg = 1'b0;
        end else begin
            m_seen = (rawq.size() >= 2) ? rawq[rawq.size()-2] : '0;
            rawq.push_back(bus.switch_raw);
            if (rawq.size() > 8) void'(rawq.pop_front());
            seenq.push_back(m_seen);
            if (seenq.size() > S) void'(seenq.pop_front());
            m_upd = '0;
            if (seenq.size() == S) begin
                for (int b = 0; b < WIDTH; b++) begin
                    m_all = 1'b1;
                    for (int j = 0; j < S; j++)
                        if (seenq[j][b] == m_sw[b]) m_all = 1'b0;
                    m_upd[b] = m_all;
                end
            end
            m_chg = |m_upd;
            m_sw  = m_sw ^ m_upd;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_switch",  32'(bus.switch),  32'(m_sw));
            chk("cyc_changed", 32'(bus.changed), 32'(m_chg));
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.switch_raw = 5'b11111;

        // Reset with all switches high
        #2 rst_n = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk("reset_sw",  32'(bus.switch),  32'h0);
        chk("reset_chg", 32'(bus.changed), 32'h0);
        wait_n(3);
        chk("reset_hold_sw", 32'(bus.switch), 32'h0);
        #2 rst_n = 1'b1;
        wait_n(5);
        chk("pwrup_k4_sw", 32'(bus.switch), 32'h00);
        wait_n(1);
        chk("pwrup_k5_sw",  32'(bus.switch),  32'h1f);
        chk("pwrup_k5_chg", 32'(bus.changed), 32'h1);
        wait_n(1);
        chk("pwrup_k6_chg", 32'(bus.changed), 32'h0);

        // Clean step
        bus.switch_raw = 5'b00000;
        wait_n(9);
        bus.switch_raw = 5'b10110;
        wait_n(5);
        chk("step_k4_sw", 32'(bus.switch), 32'h00);
        wait_n(1);
        chk("step_k5_sw",  32'(bus.switch),  32'h16);
        chk("step_k5_chg", 32'(bus.changed), 32'h1);
        wait_n(1);
        chk("step_k6_chg", 32'(bus.changed), 32'h0);

        // 3-cycle glitch on bit 0 is rejected
        bus.switch_raw = 5'b10111;
        wait_n(3);
        bus.switch_raw = 5'b10110;
        wait_n(8);
        chk("glitch3_sw", 32'(bus.switch), 32'h16);

        // 4-cycle pulse on bit 0 is accepted, then removed
        bus.switch_raw = 5'b10111;
        wait_n(4);
        bus.switch_raw = 5'b10110;
        wait_n(2);
        chk("pulse4_rise_sw",  32'(bus.switch),  32'h17);
        chk("pulse4_rise_chg", 32'(bus.changed), 32'h1);
        wait_n(3);
        chk("pulse4_hold_sw", 32'(bus.switch), 32'h17);
        wait_n(1);
        chk("pulse4_fall_sw",  32'(bus.switch),  32'h16);
        chk("pulse4_fall_chg", 32'(bus.changed), 32'h1);
        wait_n(3);

        // Bounce on bit 3
        bus.switch_raw = 5'b11110; wait_n(1);
        bus.switch_raw = 5'b10110; wait_n(1);
        bus.switch_raw = 5'b11110; wait_n(1);
        bus.switch_raw = 5'b10110; wait_n(1);
        bus.switch_raw = 5'b11110;
        wait_n(5);
        chk("bounce_k4_sw", 32'(bus.switch), 32'h16);
        wait_n(1);
        chk("bounce_k5_sw",  32'(bus.switch),  32'h1e);
        chk("bounce_k5_chg", 32'(bus.changed), 32'h1);
        wait_n(1);
        chk("bounce_k6_chg", 32'(bus.changed), 32'h0);

        // Independent bits: bit 1 at k, bit 4 at k+2
        bus.switch_raw = 5'b00000;
        wait_n(10);
        bus.switch_raw = 5'b00010;
        wait_n(2);
        bus.switch_raw = 5'b10010;
        wait_n(4);
        chk("indep_k5_sw",  32'(bus.switch),  32'h02);
        chk("indep_k5_chg", 32'(bus.changed), 32'h1);
        wait_n(2);
        chk("indep_k7_sw",  32'(bus.switch),  32'h12);
        chk("indep_k7_chg", 32'(bus.changed), 32'h1);

        // Simultaneous rise of bits 1 and 4
        bus.switch_raw = 5'b00000;
        wait_n(10);
        bus.switch_raw = 5'b10010;
        wait_n(6);
        chk("simul_k5_sw",  32'(bus.switch),  32'h12);
        chk("simul_k5_chg", 32'(bus.changed), 32'h1);
        wait_n(1);
        chk("simul_k6_chg", 32'(bus.changed), 32'h0);

        // Mid-count reset while bit 0 is counting down to 0
        bus.switch_raw = 5'b11111;
        wait_n(10);
        chk("pre_rst_sw", 32'(bus.switch), 32'h1f);
        bus.switch_raw = 5'b11110;
        wait_n(4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sw",  32'(bus.switch),  32'h0);
        chk("midrst_chg", 32'(bus.changed), 32'h0);
        wait_n(2);
        #2 rst_n = 1'b1;
        wait_n(5);
        chk("postrst_k4_sw", 32'(bus.switch), 32'h00);
        wait_n(1);
        chk("postrst_k5_sw",  32'(bus.switch),  32'h1e);
        chk("postrst_k5_chg", 32'(bus.changed), 32'h1);
        wait_n(2);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_switch_debouncer
`default_nettype wire

// File: doc/switch_debouncer.md
# switch_debouncer

Input conditioning stage between the five board slide switches and the switch-driven logic-function selector. It synchronises each asynchronous switch line into the clock domain and debounces it, so the selector's 3-bit function select and 2-bit operands only see clean, stable levels. It also raises a one-cycle strobe whenever any debounced bit changes, so downstream logic can react to a new setting.

## Interface
Parameters:
- WIDTH, 5: number of independent switch lines.
- STABLE_CYCLES, 1000000: consecutive cycles a synchronised input must differ from the debounced value before it is accepted. 1000000 is 10 ms at 100 MHz. Legal range is ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- switch_raw  input  WIDTH  raw, asynchronous switch levels from the pins.
- switch  output  WIDTH  debounced levels. Bits [4:2] carry the function select and bits [1:0] the operands.
- changed  output  1  one-cycle pulse when any bit of switch updated on the previous edge.

## Operation
- Per bit i, two-flop synchroniser: s1[i] <= switch_raw[i], then s2[i] <= s1[i]. Only s2 is used downstream of the synchroniser.
- Per bit i, a counter cnt[i] of width $clog2(STABLE_CYCLES) and a debounced register switch[i]. All bits are independent.
- Update rule per bit, evaluated at each rising edge:
  - If s2[i] == switch[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CYCLES-1: switch[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
- Any return of s2[i] to switch[i] clears the count. A glitch shorter than STABLE_CYCLES cycles (measured at s2) is therefore discarded entirely.
- changed is registered. It is 1 for exactly the cycle following any edge at which at least one switch bit updated, and 0 otherwise.
- When several bits update at the same edge, a single changed pulse covers all of them. Updates on consecutive edges produce changed high on consecutive cycles.
- The counter cannot overflow, because it wraps to 0 exactly at STABLE_CYCLES-1.
- Reset (rst_n low, asynchronous, at any time including mid-count): s1, s2, cnt, switch and changed are all forced to 0 immediately.
- After reset releases, inputs that are held high propagate like any other 0→1 transition. There is no special power-up loading.

## Timing
- Reset values: switch = 0, changed = 0.
- Latency, with S = STABLE_CYCLES and a raw level change first sampled by s1 at edge k and then held:
  - s2 reflects the new level after edge k+1.
  - cnt counts at edges k+2 through k+S.
  - switch updates at edge k+S+1.
  - changed is high during the cycle after edge k+S+1.
- Minimum accepted pulse width at s2 is S cycles. A pulse of S-1 cycles produces no output change.
- Bounce: every mismatch→match→mismatch sequence restarts the count. Latency is therefore measured from the last transition.
- The switch output is glitch-free: it is driven directly from flops and changes only on clk edges.

## Test plan
All scenarios use STABLE_CYCLES=4 and WIDTH=5.
- Reset: drive switch_raw=5'b11111 and hold rst_n low for 3 cycles -> switch=0 and changed=0 throughout reset. After rst_n rises, switch=5'b11111 at edge k+5 (k = first sampling edge) and changed pulses once.
- Clean step: switch_raw goes 5'b00000→5'b10110 before edge k -> switch stays 0 through edge k+4, becomes 5'b10110 at edge k+5, and changed is high for exactly one cycle.
- Glitch rejection: bit 0 goes high for 3 cycles then returns low -> switch[0] never changes and changed stays 0. Repeat with a 4-cycle pulse -> switch[0] rises and then falls 5 edges after the return, producing two separate changed pulses.
- Bounce: bit 3 toggles 1,0,1,0,1 every cycle and then holds 1 -> switch[3] rises 5 edges after the final transition, with one changed pulse.
- Independent bits: bit 1 rises at edge k and bit 4 rises at edge k+2 -> switch[1] updates at k+5 and switch[4] at k+7. changed is high in the cycles after both edges. A simultaneous rise of both bits gives a single pulse.
- Mid-count reset: assert rst_n low when cnt=2 -> all outputs 0 immediately. After release the full 5-edge latency applies again.
